// File: rtl/reset_sequencer_if.sv
// Reset sequencer bundle: lock/request inputs toward the sequencer and the
// three staged domain resets plus status coming back out of it.
interface reset_sequencer_if;
  logic       i_pll_locked;
  logic       i_sw_rst_req;
  logic       i_wdt_rst_req;
  logic       o_mem_rst_n;
  logic       o_periph_rst_n;
  logic       o_core_rst_n;
  logic       o_busy;
  logic [1:0] o_rst_cause;

  // System side: supplies lock status and reset requests, observes domain resets
  modport master (
    output i_pll_locked, i_sw_rst_req, i_wdt_rst_req,
    input  o_mem_rst_n, o_periph_rst_n, o_core_rst_n, o_busy, o_rst_cause
  );

  // Sequencer side
  modport slave (
    input  i_pll_locked, i_sw_rst_req, i_wdt_rst_req,
    output o_mem_rst_n, o_periph_rst_n, o_core_rst_n, o_busy, o_rst_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a filtered PLL lock, releases the mem, periph and
// core domains one stage apart, and pulls all three back into reset together on
// PLL loss, watchdog or software requests, remembering the cause.
module reset_sequencer #(
  parameter int LOCK_FILT   = 4,
  parameter int STAGE_DLY   = 8,
  parameter int ASSERT_HOLD = 16
) (
  input  logic             i_aclk,
  input  logic             i_rst,
  reset_sequencer_if.slave rst_if
);

  localparam int DLY_MAX = (STAGE_DLY > ASSERT_HOLD) ? STAGE_DLY : ASSERT_HOLD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int LCK_W   = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  localparam logic [DLY_W-1:0] STAGE_LAST = DLY_W'(STAGE_DLY - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(ASSERT_HOLD - 1);
  localparam logic [DLY_W-1:0] DLY_SAT    = DLY_W'(DLY_MAX);
  localparam logic [LCK_W-1:0] LOCK_LAST  = LCK_W'(LOCK_FILT - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_PLL = 2'b11;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_REL_MEM,
    ST_REL_PERIPH,
    ST_RUN,
    ST_ASSERT
  } state_e;

  state_e           r_state;
  logic [LCK_W-1:0] r_lock_cnt;
  logic [DLY_W-1:0] r_dly_cnt;
  logic             r_mem_rst_n;
  logic             r_periph_rst_n;
  logic             r_core_rst_n;
  logic             r_busy;
  logic [1:0]       r_cause;

  state_e           w_state_nxt;
  logic [LCK_W-1:0] w_lock_cnt_nxt;
  logic [DLY_W-1:0] w_dly_cnt_nxt;
  logic [1:0]       w_evt_cause;
  logic             w_mem_rst_n_nxt;
  logic             w_periph_rst_n_nxt;
  logic             w_core_rst_n_nxt;
  logic             w_busy_nxt;
  logic [1:0]       w_cause_nxt;

  // State, counters and the registered outputs; block reset pins every domain in reset.
  always_ff @(posedge i_aclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= ST_HOLD;
      r_lock_cnt     <= '0;
      r_dly_cnt      <= '0;
      r_mem_rst_n    <= 1'b0;
      r_periph_rst_n <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_busy         <= 1'b1;
      r_cause        <= CAUSE_POR;
    end else begin
      r_state        <= w_state_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_dly_cnt      <= w_dly_cnt_nxt;
      r_mem_rst_n    <= w_mem_rst_n_nxt;
      r_periph_rst_n <= w_periph_rst_n_nxt;
      r_core_rst_n   <= w_core_rst_n_nxt;
      r_busy         <= w_busy_nxt;
      r_cause        <= w_cause_nxt;
    end
  end

  // Next state, lock filter and shared stage/hold delay counter (cleared on any state change, saturating).
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = '0;
    w_evt_cause    = CAUSE_PLL;
    case (r_state)
      ST_HOLD: w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (rst_if.i_pll_locked) begin
          if (r_lock_cnt == LOCK_LAST) w_state_nxt = ST_REL_MEM;
          else w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
      end
      ST_REL_MEM: begin
        if (!rst_if.i_pll_locked) w_state_nxt = ST_ASSERT;
        else if (r_dly_cnt == STAGE_LAST) w_state_nxt = ST_REL_PERIPH;
      end
      ST_REL_PERIPH: begin
        if (!rst_if.i_pll_locked) w_state_nxt = ST_ASSERT;
        else if (r_dly_cnt == STAGE_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!rst_if.i_pll_locked) begin
          w_state_nxt = ST_ASSERT;
        end else if (rst_if.i_wdt_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_evt_cause = CAUSE_WDT;
        end else if (rst_if.i_sw_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_evt_cause = CAUSE_SW;
        end
      end
      ST_ASSERT: begin
        if (r_dly_cnt == HOLD_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      default: w_state_nxt = ST_HOLD;
    endcase

    if (w_state_nxt != r_state) begin
      w_dly_cnt_nxt = '0;
    end else if ((r_state == ST_REL_MEM || r_state == ST_REL_PERIPH || r_state == ST_ASSERT)
                 && r_dly_cnt != DLY_SAT) begin
      w_dly_cnt_nxt = r_dly_cnt + 1'b1;
    end else begin
      w_dly_cnt_nxt = r_dly_cnt;
    end
  end

  // Output values for the coming state, so each domain changes on its transition edge.
  always_comb begin
    w_mem_rst_n_nxt    = 1'b0;
    w_periph_rst_n_nxt = 1'b0;
    w_core_rst_n_nxt   = 1'b0;
    w_busy_nxt         = 1'b1;
    w_cause_nxt        = r_cause;
    case (w_state_nxt)
      ST_REL_MEM: begin
        w_mem_rst_n_nxt = 1'b1;
      end
      ST_REL_PERIPH: begin
        w_mem_rst_n_nxt    = 1'b1;
        w_periph_rst_n_nxt = 1'b1;
      end
      ST_RUN: begin
        w_mem_rst_n_nxt    = 1'b1;
        w_periph_rst_n_nxt = 1'b1;
        w_core_rst_n_nxt   = 1'b1;
        w_busy_nxt         = 1'b0;
      end
      ST_ASSERT: begin
        if (r_state != ST_ASSERT) w_cause_nxt = w_evt_cause;
      end
      default: begin
        w_busy_nxt = 1'b1;
      end
    endcase
  end

  assign rst_if.o_mem_rst_n    = r_mem_rst_n;
  assign rst_if.o_periph_rst_n = r_periph_rst_n;
  assign rst_if.o_core_rst_n   = r_core_rst_n;
  assign rst_if.o_busy         = r_busy;
  assign rst_if.o_rst_cause    = r_cause;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter LOCK_FILT, default 4: consecutive cycles i_pll_locked must be high before release begins; legal values are 1..255.
REQ-002 Parameter STAGE_DLY, default 8: cycles between successive domain releases; legal values are 1..1023.
REQ-003 Parameter ASSERT_HOLD, default 16: cycles all domains are held in reset after a runtime reset event; legal values are 1..1023.
REQ-004 Port i_aclk, input, 1: sole clock; every port below is synchronous to it.
REQ-005 Port i_rst, input, 1: asynchronous, active-low block reset; assertion is immediate, and i_rst is already synchronously deasserted upstream.
REQ-006 Port i_pll_locked, input, 1: PLL lock status, high = locked.
REQ-007 Port i_sw_rst_req, input, 1: software reset request, sampled level, one-cycle pulse expected.
REQ-008 Port i_wdt_rst_req, input, 1: watchdog reset request, sampled level.
REQ-009 Port o_mem_rst_n, output, 1: memory-domain reset, active-low, registered.
REQ-010 Port o_periph_rst_n, output, 1: peripheral-domain reset, active-low, registered.
REQ-011 Port o_core_rst_n, output, 1: core-domain reset, active-low, registered.
REQ-012 Port o_busy, output, 1: high whenever the block is in any state other than RUN.
REQ-013 Port o_rst_cause, output, 2: cause of the last reset; 00 = POR, 01 = SW, 10 = WDT, 11 = PLL loss.

Function
REQ-014 The FSM SHALL have six states: HOLD, WAIT_LOCK, REL_MEM, REL_PERIPH, RUN, ASSERT.
REQ-015 HOLD SHALL go to WAIT_LOCK on the first edge after i_rst deasserts, with all inputs ignored in HOLD.
REQ-016 In WAIT_LOCK, the lock counter SHALL increment on each edge with i_pll_locked=1 and clear on each edge with i_pll_locked=0.
REQ-017 In WAIT_LOCK, the edge with i_pll_locked=1 and counter=LOCK_FILT-1 SHALL enter REL_MEM and set o_mem_rst_n=1 on that same edge.
REQ-018 REL_MEM SHALL last STAGE_DLY cycles, then enter REL_PERIPH and set o_periph_rst_n=1 on the transition edge.
REQ-019 REL_PERIPH SHALL last STAGE_DLY cycles, then enter RUN, setting o_core_rst_n=1 and o_busy=0 on the transition edge.
REQ-020 Release latency SHALL therefore be: mem at edge 1+LOCK_FILT, periph at 1+LOCK_FILT+STAGE_DLY, core at 1+LOCK_FILT+2*STAGE_DLY, counting edges after i_rst deassertion.
REQ-021 In RUN, an edge sampling i_pll_locked=0, i_wdt_rst_req=1 or i_sw_rst_req=1 SHALL enter ASSERT.
REQ-022 On that ASSERT entry edge, all three rst_n outputs SHALL go 0, o_busy SHALL go 1 and o_rst_cause SHALL be updated.
REQ-023 Simultaneous events SHALL be prioritised PLL loss > WDT > SW, and only the highest-priority cause SHALL be recorded.
REQ-024 In REL_MEM or REL_PERIPH, i_pll_locked=0 SHALL enter ASSERT with cause 11.
REQ-025 In HOLD, WAIT_LOCK, REL_MEM, REL_PERIPH and ASSERT, i_sw_rst_req and i_wdt_rst_req SHALL be ignored and dropped.
REQ-026 ASSERT SHALL last ASSERT_HOLD cycles regardless of inputs, then enter WAIT_LOCK with the lock counter cleared.
REQ-027 Domain release order SHALL always be mem, then periph, then core, and reassertion SHALL act on all three domains on the same edge.
REQ-028 The shared delay counter SHALL be sized $clog2(max(STAGE_DLY,ASSERT_HOLD)+1), SHALL reload to 0 on every state change and SHALL never wrap.
REQ-029 o_rst_cause SHALL hold its value until the next ASSERT entry or the next i_rst assertion.

Reset
REQ-030 While i_rst=0, the block SHALL asynchronously force o_mem_rst_n=0, o_periph_rst_n=0, o_core_rst_n=0, o_busy=1, o_rst_cause=00, state=HOLD and all counters=0.
REQ-031 i_rst assertion in any state, including mid-sequence or mid-ASSERT, SHALL apply REQ-030 immediately, and the sequence SHALL restart from HOLD.

Verification
REQ-032 POR, defaults, lock held high: mem rises at edge 5, periph at edge 13, core at edge 21; o_busy falls at edge 21; cause=00.
REQ-033 Lock glitch: lock high 3 cycles, low 1 cycle, then high: mem release is delayed to 4 consecutive high samples after the glitch.
REQ-034 In RUN, a 1-cycle i_sw_rst_req: all rst_n go 0 on the next edge, cause=01, held 16 cycles, then the re-release sequence completes with mem +4, periph +12, core +20 edges after ASSERT exit.
REQ-035 In RUN, i_wdt_rst_req and i_pll_locked=0 on the same cycle: cause=11; a later SW pulse during ASSERT is ignored.
REQ-036 Lock loss in REL_PERIPH: mem goes 0 on the next edge and cause=11; i_sw_rst_req pulsed in WAIT_LOCK produces no effect.
REQ-037 i_rst asserted mid-REL_MEM between clock edges: outputs go 0 without a clock edge, then the full sequence is re-timed as in REQ-032.
